// File: rtl/sd_view_pkg.sv
// Shared definitions for the SD byte viewer.
//   state_t : viewer FSM encoding (IDLE, ISSUE, WAIT, SHOW)
//   BYTE_W  : width of one BRAM/display byte
package sd_view_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SHOW  = 2'd3
  } state_t;

endpackage

// File: rtl/bram_byte_viewer_if.sv
// BRAM read port plus display hand-off of the byte viewer.
//   bram_en/bram_addr : read request towards the BRAM (viewer drives)
//   bram_dout         : read data, valid one clk after bram_en
//   disp_data/addr    : byte and its address for the display stage
//   disp_valid        : disp_* are stable and current
interface bram_byte_viewer_if #(
  parameter int ADDR_W = 9
);
  import sd_view_pkg::*;

  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [BYTE_W-1:0] bram_dout;
  logic [BYTE_W-1:0] disp_data;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_valid;

  modport master (
    output bram_en, bram_addr, disp_data, disp_addr, disp_valid,
    input  bram_dout
  );

  modport slave (
    input  bram_en, bram_addr, disp_data, disp_addr, disp_valid,
    output bram_dout
  );

endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, debouncer, rising-edge pulse.
//   clk, reset : system clock, synchronous active-low reset
//   btn        : raw asynchronous button
//   step       : one-cycle pulse when the accepted level goes 0 -> 1
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic step
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
      step    <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      step    <= 1'b0;
      // Level flips on the DEBOUNCE_CYCLES-th consecutive differing cycle.
      if (sync_p1 != level) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync_p1;
          cnt   <= '0;
          step  <= sync_p1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/bram_byte_viewer.sv
// Browses a byte-wide BRAM one address at a time and hands the byte to a
// display stage. Buttons step forward/backward, auto_en steps forward
// periodically, load_done (re)starts browsing at address 0.
//   clk, reset          : system clock, synchronous active-low reset
//   btn_next, btn_prev  : raw push-buttons
//   auto_en             : auto-advance enable (level)
//   load_done           : pulse, BRAM contents valid
//   bus (master)        : BRAM read port and display outputs
module bram_byte_viewer
  import sd_view_pkg::*;
#(
  parameter int ADDR_W          = 9,
  parameter int LAST_ADDR       = 511,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int AUTO_PERIOD     = 50_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_next,
  input  logic                btn_prev,
  input  logic                auto_en,
  input  logic                load_done,
  bram_byte_viewer_if.master  bus
);

  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(LAST_ADDR);
  localparam int                AUTO_W = $clog2(AUTO_PERIOD + 1);

  function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
    return (a >= LAST) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [ADDR_W-1:0] addr_prev(input logic [ADDR_W-1:0] a);
    return (a == '0) ? LAST : a - 1'b1;
  endfunction

  logic              next_p0;
  logic              prev_p0;
  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] target_n;
  logic              capture;
  logic              step_take;
  logic [AUTO_W-1:0] auto_cnt;
  logic              auto_pulse;
  logic [BYTE_W-1:0] disp_data_p1;
  logic [ADDR_W-1:0] disp_addr_p1;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_next),
    .step  (next_p0)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_prev),
    .step  (prev_p0)
  );

  // Auto-advance: a registered pulse one cycle after the count wraps, so a
  // full step period is AUTO_PERIOD + 1 + the two fetch cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      auto_cnt   <= '0;
      auto_pulse <= 1'b0;
    end else if (state != ST_SHOW || !auto_en || step_take) begin
      auto_cnt   <= '0;
      auto_pulse <= 1'b0;
    end else if (auto_cnt == AUTO_W'(AUTO_PERIOD - 1)) begin
      auto_cnt   <= '0;
      auto_pulse <= 1'b1;
    end else begin
      auto_cnt   <= auto_cnt + 1'b1;
      auto_pulse <= 1'b0;
    end
  end

  always_comb begin
    state_n   = state;
    target_n  = target;
    capture   = 1'b0;
    step_take = 1'b0;
    case (state)
      ST_IDLE:  state_n = ST_IDLE;
      ST_ISSUE: state_n = ST_WAIT;
      ST_WAIT: begin
        state_n = ST_SHOW;
        capture = 1'b1;
      end
      ST_SHOW: begin
        // Opposite button pulses cancel; a button step overrides auto.
        if (next_p0 ^ prev_p0) begin
          step_take = 1'b1;
          state_n   = ST_ISSUE;
          target_n  = next_p0 ? addr_next(target) : addr_prev(target);
        end else if (auto_pulse && auto_en) begin
          step_take = 1'b1;
          state_n   = ST_ISSUE;
          target_n  = addr_next(target);
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // A fresh load restarts from address 0 from any state.
    if (load_done) begin
      state_n   = ST_ISSUE;
      target_n  = '0;
      capture   = 1'b0;
      step_take = 1'b0;
    end
  end

  // Stage boundary: state/target register, capture of BRAM data into display
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      target       <= '0;
      disp_data_p1 <= '0;
      disp_addr_p1 <= '0;
    end else begin
      state  <= state_n;
      target <= target_n;
      if (capture) begin
        disp_data_p1 <= bus.bram_dout;
        disp_addr_p1 <= target;
      end
    end
  end

  // target only moves when entering ISSUE, so it doubles as a held bram_addr.
  assign bus.bram_en    = (state == ST_ISSUE);
  assign bus.bram_addr  = target;
  assign bus.disp_valid = (state == ST_SHOW);
  assign bus.disp_data  = disp_data_p1;
  assign bus.disp_addr  = disp_addr_p1;

endmodule
